// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC port indices, flit field offsets and the XY route helper.
package noc_pkg;
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;
  localparam int NUM_PORTS = 5;
  // Dest X sits at the flit LSBs; dest Y follows immediately above it.
  localparam int X_LSB = 0;
  function automatic logic [NUM_PORTS-1:0] xy_route(input int unsigned dx, dy, cx, cy);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    r[dx > cx ? PORT_E : dx < cx ? PORT_W : dy > cy ? PORT_N : dy < cy ? PORT_S : PORT_L] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: flit buffer with wrap-bit pointers; storage is not reset, data_o reads 0 when empty.
module noc_flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push, pop;
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/noc_input_unit.sv
// noc_input_unit: input FIFO plus XY route computation producing a one-hot output request.
// NOC_ROUTE_REG_EN registers the route (req_o two cycles after push, one idle cycle between grants).
module noc_input_unit
  import noc_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 4,
  parameter int          X_W    = 2,
  parameter int          Y_W    = 2,
  parameter int unsigned CUR_X  = 0,
  parameter int unsigned CUR_Y  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [NUM_PORTS-1:0]   req_o,
  output logic [DATA_W-1:0]      data_o,
  input  logic                   grant_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int Y_LSB = X_LSB + X_W;
  logic full, empty, pop;
  logic [NUM_PORTS-1:0] route_c;
  noc_flit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .push_i  (valid_i),
    .pop_i   (grant_i),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );
  assign ready_o = !full;
  assign pop     = grant_i && !empty;
  assign route_c = empty ? '0 : xy_route(32'(data_o[X_LSB +: X_W]), 32'(data_o[Y_LSB +: Y_W]), CUR_X, CUR_Y);
`ifdef NOC_ROUTE_REG_EN
  logic valid_q, valid_d;
  logic [NUM_PORTS-1:0] route_q, route_d;
  // A pop invalidates the registered route until the new head has been routed.
  always_comb begin
    valid_d = !pop && !empty;
    route_d = route_c;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      route_q <= '0;
    end else begin
      valid_q <= valid_d;
      route_q <= route_d;
    end
  end
  assign req_o = valid_q ? route_q : '0;
`else
  assign req_o = route_c;
`endif
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(grant_i && empty)) else $warning("noc_input_unit: grant while empty ignored");
      assert ($onehot0(req_o)) else $error("noc_input_unit: req_o not one-hot");
    end
  end
`endif
endmodule

// File: tb/tb_noc_input_unit.sv
// tb_noc_input_unit: randomized and directed checks of noc_input_unit against a queue model.
module tb_noc_input_unit;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CX     = 1;
  localparam int CY     = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic valid_i = 1'b0;
  logic grant_i = 1'b0;
  logic ready_o;
  logic [4:0] req_o;
  logic [DATA_W-1:0] data_o;
  logic [$clog2(DEPTH):0] count_o;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] q [$];
  bit vr = 0;
  noc_input_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .X_W(2), .Y_W(2), .CUR_X(CX), .CUR_Y(CY)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .req_o   (req_o),
    .data_o  (data_o),
    .grant_i (grant_i),
    .count_o (count_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [4:0] ref_route(input logic [DATA_W-1:0] d);
    int dx, dy;
    dx = int'(d[1:0]);
    dy = int'(d[3:2]);
    if (dx > CX) return 5'b00100;
    if (dx < CX) return 5'b01000;
    if (dy > CY) return 5'b00001;
    if (dy < CY) return 5'b00010;
    return 5'b10000;
  endfunction
  function automatic logic [DATA_W-1:0] mk(input int x, input int y, input logic [27:0] pl);
    logic [1:0] xs, ys;
    xs = 2'(x);
    ys = 2'(y);
    return {pl, ys, xs};
  endfunction
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic g);
    bit push, pop, had;
    logic [4:0] exp_req;
    valid_i = v;
    data_i  = d;
    grant_i = g;
    @(negedge clk);
`ifdef NOC_ROUTE_REG_EN
    exp_req = (vr && q.size() > 0) ? ref_route(q[0]) : 5'b0;
`else
    exp_req = q.size() > 0 ? ref_route(q[0]) : 5'b0;
`endif
    check("count", 32'(count_o), 32'(q.size()));
    check("ready", 32'(ready_o), 32'(q.size() < DEPTH));
    check("req", 32'(req_o), 32'(exp_req));
    check("data", data_o, q.size() > 0 ? q[0] : '0);
    push = v && q.size() < DEPTH;
    pop  = g && q.size() > 0;
    had  = q.size() > 0;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    vr = !pop && had;
    #1;
  endtask
  initial begin
    logic [DATA_W-1:0] f;
    @(negedge clk);
    check("rst_req", 32'(req_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_data", data_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // Each route direction, one flit at a time.
    step(1, mk(3, 1, 28'h11), 0); step(0, 0, 1);
    step(1, mk(0, 2, 28'h22), 0); step(0, 0, 1);
    step(1, mk(1, 3, 28'h33), 0); step(0, 0, 1);
    step(1, mk(1, 0, 28'h44), 0); step(0, 0, 1);
    step(1, mk(1, 1, 28'h55), 0); step(0, 0, 1);
    step(0, 0, 0);
    // Fill, then push against full with a simultaneous grant.
    for (int i = 0; i < 4; i++) step(1, $urandom, 0);
    step(1, 32'hdead_beef, 1);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    // Steady stream at occupancy 1.
    step(1, $urandom, 0);
    for (int i = 0; i < 32; i++) step(1, $urandom, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    // Grant while empty must not move pointers.
    step(0, 0, 1);
    step(0, 0, 0);
    // Asynchronous reset with flits buffered.
    for (int i = 0; i < 3; i++) step(1, $urandom, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(req_o), 0);
    check("arst_count", 32'(count_o), 0);
    q.delete();
    vr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    f = mk(2, 0, 28'hcafe);
    step(1, f, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50));
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
